// File: rtl/pixel_sequencer_pkg.sv
// Shared types and default geometry for the pixel sequencer.
package pixel_sequencer_pkg;

    localparam int LOC_SIZE          = 11;
    localparam int PIXEL_SIZE        = 24;
    localparam int FRAME_WIDTH       = 640;
    localparam int FRAME_HEIGHT      = 480;
    localparam int SEQ_FLUSH_DEFAULT = 3 * FRAME_WIDTH + 8;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_ARMED  = 3'd1,
        SEQ_ACTIVE = 3'd2,
        SEQ_FLUSH  = 3'd3,
        SEQ_DONE   = 3'd4
    } seq_state_e;

    // Width of a down-counter holding len; never narrower than one bit.
    function automatic int flush_cnt_w(input int len);
        return (len > 0) ? $clog2(len + 1) : 1;
    endfunction

endpackage

// File: rtl/pixel_sequencer_if.sv
// Input pixel stream bundle between an upstream source and the sequencer.
interface pixel_sequencer_if;
    import pixel_sequencer_pkg::*;

    // A pixel transfers on a clock edge where s_valid and s_ready are both high;
    // the source holds s_sof/s_data stable while s_valid is high and s_ready is low.
    logic                  s_valid;
    logic                  s_sof;
    logic [PIXEL_SIZE-1:0] s_data;
    logic                  s_ready;

    modport master (output s_valid, output s_sof, output s_data, input s_ready);
    modport slave  (input s_valid, input s_sof, input s_data, output s_ready);

endinterface

// File: rtl/pixel_sequencer_raster_counter.sv
// Raster x/y position register: clear to (0,0), or step with x wrapping at FRAME_W.
module pixel_sequencer_raster_counter
    import pixel_sequencer_pkg::*;
#(
    parameter int FRAME_W = FRAME_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                inc,
    output logic [LOC_SIZE-1:0] x,
    output logic [LOC_SIZE-1:0] y,
    output logic [LOC_SIZE-1:0] nx,
    output logic [LOC_SIZE-1:0] ny
);

    logic [LOC_SIZE-1:0] x_q, x_d, y_q, y_d;

    always_comb begin
        nx  = x_q + LOC_SIZE'(1);
        ny  = y_q;
        if (x_q == LOC_SIZE'(FRAME_W - 1)) begin
            nx = '0;
            ny = y_q + LOC_SIZE'(1);
        end
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (inc) begin
            x_d = nx;
            y_d = ny;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/pixel_sequencer.sv
// Turns a valid/ready pixel stream into the registered en/x/y/data raster plus drain beats.
// Build option PIXEL_SEQ_SOF_RESYNC_EN: an sof accepted mid-frame restarts the frame at (0,0).
module pixel_sequencer
    import pixel_sequencer_pkg::*;
#(
    parameter int                    FRAME_W    = FRAME_WIDTH,
    parameter int                    FRAME_H    = FRAME_HEIGHT,
    parameter int                    FLUSH_LEN  = SEQ_FLUSH_DEFAULT,
    parameter logic [PIXEL_SIZE-1:0] FLUSH_DATA = '0,
    parameter bit                    CONTINUOUS = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    pixel_sequencer_if.slave      s_if,
    output logic                  en,
    output logic [LOC_SIZE-1:0]   x,
    output logic [LOC_SIZE-1:0]   y,
    output logic [PIXEL_SIZE-1:0] data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  sof_err,
    output seq_state_e            state_dbg
);

    localparam int FCW = flush_cnt_w(FLUSH_LEN);

    seq_state_e            state_q, state_d;
    logic [FCW-1:0]        fcnt_q, fcnt_d;
    logic                  en_q, en_d;
    logic [PIXEL_SIZE-1:0] data_q, data_d;
    logic [15:0]           fcount_q, fcount_d;
    logic                  sof_err_q, sof_err_d;
    logic                  accept, last_pix, enter_flush, cnt_clear, cnt_inc;
    logic [LOC_SIZE-1:0]   nx, ny;

    assign accept   = s_if.s_valid & s_if.s_ready;
    // The pixel accepted in ACTIVE lands on (nx, ny).
    assign last_pix = (nx == LOC_SIZE'(FRAME_W - 1)) && (ny == LOC_SIZE'(FRAME_H - 1));

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        en_d        = 1'b0;
        data_d      = data_q;
        fcount_d    = fcount_q;
        sof_err_d   = sof_err_q;
        enter_flush = 1'b0;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d   = SEQ_ARMED;
                    sof_err_d = 1'b0;
                end
            end
            SEQ_ARMED: begin
                if (accept && s_if.s_sof) begin
                    en_d      = 1'b1;
                    data_d    = s_if.s_data;
                    cnt_clear = 1'b1;
                    state_d   = SEQ_ACTIVE;
                    if (FRAME_W == 1 && FRAME_H == 1) enter_flush = 1'b1;
                end
            end
            SEQ_ACTIVE: begin
                if (accept) begin
                    en_d   = 1'b1;
                    data_d = s_if.s_data;
`ifdef PIXEL_SEQ_SOF_RESYNC_EN
                    if (s_if.s_sof) begin
                        cnt_clear = 1'b1;
                        sof_err_d = 1'b1;
                    end else begin
                        cnt_inc     = 1'b1;
                        enter_flush = last_pix;
                    end
`else
                    cnt_inc     = 1'b1;
                    enter_flush = last_pix;
                    if (last_pix && s_if.s_sof) sof_err_d = 1'b1;
`endif
                end
            end
            SEQ_FLUSH: begin
                en_d    = 1'b1;
                data_d  = FLUSH_DATA;
                cnt_inc = 1'b1;
                fcnt_d  = fcnt_q - FCW'(1);
                if (fcnt_q == FCW'(1)) state_d = SEQ_DONE;
            end
            SEQ_DONE: begin
                fcount_d = fcount_q + 16'd1;
                state_d  = CONTINUOUS ? SEQ_ARMED : SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
        if (enter_flush) begin
            if (FLUSH_LEN == 0) begin
                state_d = SEQ_DONE;
            end else begin
                state_d = SEQ_FLUSH;
                fcnt_d  = FCW'(FLUSH_LEN);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            fcnt_q    <= '0;
            en_q      <= 1'b0;
            data_q    <= '0;
            fcount_q  <= '0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            en_q      <= en_d;
            data_q    <= data_d;
            fcount_q  <= fcount_d;
            sof_err_q <= sof_err_d;
        end
    end

    pixel_sequencer_raster_counter #(.FRAME_W(FRAME_W)) u_raster (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .x     (x),
        .y     (y),
        .nx    (nx),
        .ny    (ny)
    );

    assign s_if.s_ready = (state_q == SEQ_ARMED) || (state_q == SEQ_ACTIVE);
    assign busy         = s_if.s_ready || (state_q == SEQ_FLUSH);
    assign frame_done   = (state_q == SEQ_DONE);
    assign en           = en_q;
    assign data         = data_q;
    assign frame_count  = fcount_q;
    assign sof_err      = sof_err_q;
    assign state_dbg    = state_q;

endmodule
